motor_cmd_sequencer: RTL and testbench

//  Command front-end for the pulse generator stage. Buffers (motor, pulse-count) move commands in a

---
 rtl/motor_cmd_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_motor_cmd_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_cmd_sequencer.sv
// motor_cmd_sequencer
//   Command front-end for the pulse generator. Move commands (motor, pulse
//   count) are queued in a small FIFO and issued one at a time: Motor and
//   PulseNum are loaded from the FIFO head, Enable is raised and held until
//   the generator's Busy has risen and fallen again, then Enable is dropped
//   for a settle gap before the next command.
//
// Ports
//   clk         system clock
//   rst         asynchronous reset, active low
//   cmd_valid   command present on cmd_motor / cmd_pulses
//   cmd_ready   FIFO not full; a command transfers on cmd_valid & cmd_ready
//   cmd_motor   motor index 0..5 (6 and 7 are rejected with err)
//   cmd_pulses  pulse count (0 completes immediately without Enable)
//   abort       flush FIFO, stop the current move, go to the settle gap
//   Motor       motor select to the generator
//   Enable      enable to the generator
//   PulseNum    pulse count to the generator
//   Busy        busy flag from the generator
//   done        one-cycle pulse: a command completed
//   done_motor  motor of the completed command, valid with done
//   err         one-cycle pulse: bad motor index or arm timeout
//   level       FIFO occupancy
//   idle        FIFO empty and sequencer idle
module motor_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int PN_W    = 10,
    parameter int ARM_TO  = 8,
    parameter int GAP_CYC = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_motor,
    input  logic [PN_W-1:0]          cmd_pulses,
    input  logic                     abort,
    output logic [2:0]               Motor,
    output logic                     Enable,
    output logic [PN_W-1:0]          PulseNum,
    input  logic                     Busy,
    output logic                     done,
    output logic [2:0]               done_motor,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     idle
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(ARM_TO + 1);
    localparam int GW = $clog2(GAP_CYC + 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [2:0]    MAX_MOTOR = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ARM,
        S_RUN,
        S_GAP
    } state_t;

    state_t          state, state_nx;

    logic [2:0]      fifo_motor  [DEPTH];
    logic [PN_W-1:0] fifo_pulses [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            push, pop;

    logic [TW-1:0]   timer, timer_nx;
    logic [GW-1:0]   gap_cnt, gap_nx;
    logic [2:0]      motor_nx, dmot_nx;
    logic [PN_W-1:0] pn_nx;
    logic            en_nx, done_nx, err_nx;

    // abort wins over both FIFO ports so a flush never leaves a stray entry
    assign cmd_ready = (level != FULL_LVL);
    assign push      = cmd_valid & cmd_ready & ~abort;
    assign pop       = (state == S_IDLE) & (level != '0) & ~abort;
    assign idle      = (state == S_IDLE) & (level == '0);

    // FIFO storage: data only, no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_motor[wr_ptr]  <= cmd_motor;
            fifo_pulses[wr_ptr] <= cmd_pulses;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is a power of two)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // FSM and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            Motor      <= '0;
            PulseNum   <= '0;
            Enable     <= 1'b0;
            done       <= 1'b0;
            done_motor <= '0;
            err        <= 1'b0;
            timer      <= '0;
            gap_cnt    <= '0;
        end else begin
            state      <= state_nx;
            Motor      <= motor_nx;
            PulseNum   <= pn_nx;
            Enable     <= en_nx;
            done       <= done_nx;
            done_motor <= dmot_nx;
            err        <= err_nx;
            timer      <= timer_nx;
            gap_cnt    <= gap_nx;
        end
    end

    always_comb begin
        state_nx = state;
        motor_nx = Motor;
        pn_nx    = PulseNum;
        en_nx    = Enable;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        dmot_nx  = done_motor;
        timer_nx = timer;
        gap_nx   = gap_cnt;

        if (abort) begin
            // drop everything, no completion report, settle before next command
            en_nx    = 1'b0;
            gap_nx   = '0;
            state_nx = S_GAP;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        motor_nx = fifo_motor[rd_ptr];
                        pn_nx    = fifo_pulses[rd_ptr];
                        state_nx = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (Motor > MAX_MOTOR) begin
                        err_nx   = 1'b1;
                        state_nx = S_IDLE;
                    end else if (PulseNum == '0) begin
                        done_nx  = 1'b1;
                        dmot_nx  = Motor;
                        state_nx = S_IDLE;
                    end else begin
                        en_nx    = 1'b1;
                        timer_nx = '0;
                        state_nx = S_ARM;
                    end
                end
                S_ARM: begin
                    // timer counts ARM cycles without Busy; the ARM_TO-th such cycle times out
                    if (Busy) begin
                        state_nx = S_RUN;
                    end else if (timer == TW'(ARM_TO - 1)) begin
                        err_nx   = 1'b1;
                        en_nx    = 1'b0;
                        gap_nx   = '0;
                        state_nx = S_GAP;
                    end else begin
                        timer_nx = timer + TW'(1);
                    end
                end
                S_RUN: begin
                    if (!Busy) begin
                        en_nx    = 1'b0;
                        done_nx  = 1'b1;
                        dmot_nx  = Motor;
                        gap_nx   = '0;
                        state_nx = S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GW'(GAP_CYC - 1)) begin
                        state_nx = S_IDLE;
                    end else begin
                        gap_nx = gap_cnt + GW'(1);
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Bench for motor_cmd_sequencer: directed scenarios plus a randomized phase,
// checked against a transaction-level scoreboard of accepted commands and a
// behavioural generator model driving Busy.
module tb_motor_cmd_sequencer;

    localparam int DEPTH   = 4;
    localparam int PN_W    = 10;
    localparam int ARM_TO  = 8;
    localparam int GAP_CYC = 2;

    // expected outcome of a command
    localparam int K_BAD  = 0;  // err, Enable never raised
    localparam int K_ZERO = 1;  // done, Enable never raised
    localparam int K_RUN  = 2;  // Enable, generator runs, done
    localparam int K_TMO  = 3;  // Enable, generator silent, err after ARM_TO

    typedef struct {
        int motor;
        int pulses;
        int kind;
        int delay;
        int len;
    } cmd_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   cmd_valid = 1'b0;
    logic                   cmd_ready;
    logic [2:0]             cmd_motor = '0;
    logic [PN_W-1:0]        cmd_pulses = '0;
    logic                   abort = 1'b0;
    logic [2:0]             Motor;
    logic                   Enable;
    logic [PN_W-1:0]        PulseNum;
    logic                   Busy = 1'b0;
    logic                   done;
    logic [2:0]             done_motor;
    logic                   err;
    logic [$clog2(DEPTH):0] level;
    logic                   idle;

    cmd_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   noise_en = 1'b0;
    bit   en_seen = 1'b0;

    motor_cmd_sequencer #(
        .DEPTH(DEPTH), .PN_W(PN_W), .ARM_TO(ARM_TO), .GAP_CYC(GAP_CYC)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_motor(cmd_motor), .cmd_pulses(cmd_pulses), .abort(abort),
        .Motor(Motor), .Enable(Enable), .PulseNum(PulseNum), .Busy(Busy),
        .done(done), .done_motor(done_motor), .err(err),
        .level(level), .idle(idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic cmd_t mk(input int m, input int p, input bit dead, input int dly, input int len);
        cmd_t c;
        c.motor  = m;
        c.pulses = p;
        c.delay  = dly;
        c.len    = len;
        if (m > 5)        c.kind = K_BAD;
        else if (p == 0)  c.kind = K_ZERO;
        else if (dead)    c.kind = K_TMO;
        else              c.kind = K_RUN;
        return c;
    endfunction

    // Generator model: after Enable rises, waits 'delay' cycles, holds Busy for
    // 'len' cycles, then stays quiet until Enable drops. Silent for K_TMO.
    // With noise_en, Busy toggles randomly whenever Enable is low.
    int g_cnt = 0;
    bit g_started = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!Enable || !rst) begin
                g_cnt = 0;
                g_started = 1'b0;
                Busy = (noise_en && rst) ? 1'($urandom_range(0, 1)) : 1'b0;
            end else if (exp_q.size() == 0 || exp_q[0].kind != K_RUN) begin
                Busy = 1'b0;
            end else if (!g_started) begin
                if (g_cnt >= exp_q[0].delay) begin
                    Busy = 1'b1;
                    g_started = 1'b1;
                    g_cnt = 0;
                end else begin
                    Busy = 1'b0;
                    g_cnt++;
                end
            end else if (Busy) begin
                if (g_cnt >= exp_q[0].len) Busy = 1'b0;
                else g_cnt++;
            end
        end
    end

    // Scoreboard monitor, sampled on the falling edge
    logic            en_prev = 1'b0;
    logic [2:0]      en_motor = '0;
    logic [PN_W-1:0] en_pn = '0;
    int              rise_cyc = 0;
    int              low_cnt = 0;
    bit              fell_seen = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                en_prev = 1'b0;
                fell_seen = 1'b0;
                low_cnt = 0;
            end else begin
                if (done || err) chk("done_err_excl", 32'(done & err), 32'd0);
                if (Enable && !en_prev) begin
                    en_seen = 1'b1;
                    if (exp_q.size() == 0) begin
                        chk("en_rise_unexpected", 32'd1, 32'd0);
                    end else begin
                        chk("en_rise_runnable",
                            32'(exp_q[0].kind == K_RUN || exp_q[0].kind == K_TMO), 32'd1);
                        chk("en_rise_motor", 32'(Motor), 32'(exp_q[0].motor));
                        chk("en_rise_pulses", 32'(PulseNum), 32'(exp_q[0].pulses));
                    end
                    if (fell_seen) chk("enable_gap_low", 32'(low_cnt >= GAP_CYC), 32'd1);
                    rise_cyc = cyc;
                    en_motor = Motor;
                    en_pn = PulseNum;
                end else if (Enable) begin
                    chk("hold_motor", 32'(Motor), 32'(en_motor));
                    chk("hold_pulses", 32'(PulseNum), 32'(en_pn));
                end
                if (!Enable) begin
                    if (en_prev) begin
                        fell_seen = 1'b1;
                        low_cnt = 1;
                    end else begin
                        low_cnt++;
                    end
                end
                if (err) begin
                    if (exp_q.size() == 0) begin
                        chk("err_unexpected", 32'd1, 32'd0);
                    end else begin
                        chk("err_kind", 32'(exp_q[0].kind == K_BAD || exp_q[0].kind == K_TMO), 32'd1);
                        if (exp_q[0].kind == K_TMO) begin
                            chk("timeout_latency", 32'(cyc - rise_cyc), 32'(ARM_TO));
                            chk("timeout_enable_low", 32'(Enable), 32'd0);
                        end
                        void'(exp_q.pop_front());
                    end
                end
                if (done) begin
                    if (exp_q.size() == 0) begin
                        chk("done_unexpected", 32'd1, 32'd0);
                    end else begin
                        chk("done_kind", 32'(exp_q[0].kind == K_ZERO || exp_q[0].kind == K_RUN), 32'd1);
                        chk("done_motor", 32'(done_motor), 32'(exp_q[0].motor));
                        void'(exp_q.pop_front());
                    end
                end
                en_prev = Enable;
            end
        end
    end

    // Driver tasks: all start and end 2 time units after a rising edge
    task automatic push(input int m, input int p, input bit dead, input int dly, input int len,
                        output bit acc);
        cmd_valid  = 1'b1;
        cmd_motor  = 3'(m);
        cmd_pulses = PN_W'(p);
        @(negedge clk);
        acc = cmd_ready && !abort;
        @(posedge clk);
        #2;
        cmd_valid = 1'b0;
        if (acc) exp_q.push_back(mk(m, p, dead, dly, len));
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !idle) && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk(tag, 32'(exp_q.size() == 0 && idle), 32'd1);
    endtask

    task automatic wait_run(input string tag, input bit need_busy, input int budget);
        int n;
        n = 0;
        while (!(Enable && (!need_busy || Busy)) && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk(tag, 32'(Enable && (!need_busy || Busy)), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_Motor"}, 32'(Motor), 32'd0);
        chk({tag, "_Enable"}, 32'(Enable), 32'd0);
        chk({tag, "_PulseNum"}, 32'(PulseNum), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_done_motor"}, 32'(done_motor), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_level"}, 32'(level), 32'd0);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_idle"}, 32'(idle), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   acc;
        bit   ab;
        cmd_t cur;

        // reset state
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;

        // 1: single move, Enable two cycles after the push edge
        push(2, 5, 1'b0, 1, 5, acc);
        chk("t1_accept", 32'(acc), 32'd1);
        @(negedge clk);
        chk("t1_enable_c0", 32'(Enable), 32'd0);
        @(negedge clk);
        chk("t1_enable_c1", 32'(Enable), 32'd0);
        @(negedge clk);
        chk("t1_enable_c2", 32'(Enable), 32'd1);
        @(posedge clk);
        #2;
        drain("t1_drain", 100);

        // 2: fill the FIFO while the generator is busy with a long move
        push(0, 100, 1'b0, 0, 40, acc);
        wait_run("t2_running", 1'b0, 20);
        for (int i = 0; i < 4; i++) begin
            push(i + 1, 10 + i, 1'b0, 1, 3, acc);
            chk("t2_accept", 32'(acc), 32'd1);
        end
        chk("t2_level_full", 32'(level), 32'(DEPTH));
        push(5, 20, 1'b0, 1, 3, acc);
        chk("t2_fifth_refused", 32'(acc), 32'd0);
        drain("t2_drain", 400);

        // 3: bad motor then zero pulses, Enable never raised
        en_seen = 1'b0;
        push(7, 10, 1'b0, 0, 3, acc);
        push(1, 0, 1'b0, 0, 3, acc);
        drain("t3_drain", 50);
        chk("t3_no_enable", 32'(en_seen), 32'd0);

        // 4: silent generator times out, following command still runs
        push(3, 4, 1'b1, 0, 0, acc);
        push(4, 6, 1'b0, 2, 3, acc);
        drain("t4_drain", 200);

        // 5: abort during RUN with two queued commands
        push(5, 50, 1'b0, 0, 40, acc);
        wait_run("t5_running", 1'b1, 20);
        push(1, 1, 1'b0, 0, 2, acc);
        push(2, 2, 1'b0, 0, 2, acc);
        chk("t5_level_queued", 32'(level), 32'd2);
        abort = 1'b1;
        @(posedge clk);
        #2;
        abort = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("t5_enable_dropped", 32'(Enable), 32'd0);
        chk("t5_level_flushed", 32'(level), 32'd0);
        chk("t5_no_done", 32'(done), 32'd0);
        chk("t5_not_idle_yet", 32'(idle), 32'd0);
        repeat (GAP_CYC + 1) @(posedge clk);
        #2;
        chk("t5_idle_after_gap", 32'(idle), 32'd1);

        // randomized traffic with occasional aborts and Busy noise when Enable is low
        noise_en = 1'b1;
        for (int i = 0; i < 500; i++) begin
            cur = mk(int'($urandom_range(0, 7)),
                     ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 1023)),
                     ($urandom_range(0, 7) == 0),
                     int'($urandom_range(0, 4)),
                     int'($urandom_range(1, 6)));
            cmd_valid  = ($urandom_range(0, 2) == 0);
            cmd_motor  = 3'(cur.motor);
            cmd_pulses = PN_W'(cur.pulses);
            abort      = ($urandom_range(0, 59) == 0);
            @(negedge clk);
            acc = cmd_valid && cmd_ready && !abort;
            ab  = abort;
            @(posedge clk);
            #2;
            if (ab) exp_q.delete();
            else if (acc) exp_q.push_back(cur);
        end
        cmd_valid = 1'b0;
        abort = 1'b0;
        drain("rand_drain", 2000);
        noise_en = 1'b0;

        // 6: asynchronous reset in the middle of RUN
        push(0, 9, 1'b0, 0, 20, acc);
        wait_run("t6_running", 1'b1, 20);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_reset_values("t6_async");
        exp_q.delete();
        @(posedge clk);
        #2;
        rst = 1'b1;
        push(2, 3, 1'b0, 1, 2, acc);
        drain("t6_recover", 100);
        chk("final_level", 32'(level), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
